// File: rtl/aes_round_engine.sv
// Iterative AES-128/192/256 block engine: one round per clock, valid/ready on input and output.
// Define AES_ROUND_ENGINE_DEC_EN to compile in the decrypt datapath and the mode register.
module aes_round_engine #(
   parameter int Nk = 4,
   parameter int Nb = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  keys_valid,
   input  logic [128*(Nk+7)-1:0] round_keys,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  mode,
   input  logic [127:0]          in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [127:0]          out,
   output logic                  out_mode,
   output logic                  busy
);
   localparam int Nr = Nk + 6;
   localparam int KW = 128 * (Nr + 1);
   localparam logic [3:0] NR_CNT = 4'(Nr);

   if (Nb != 4) begin : g_nb_check
      $error("aes_round_engine: Nb must be 4");
   end
   if (Nk != 4 && Nk != 6 && Nk != 8) begin : g_nk_check
      $error("aes_round_engine: Nk must be 4, 6 or 8");
   end

   typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;
   fsm_t fsm, fsm_next;

   logic [127:0] blk, enc_next, load_val, round_val;
   logic [3:0]   cnt;
   logic         accept;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box requires.
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] p, r;
      p = a;
      r = 8'h01;
      for (int i = 0; i < 7; i++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] x;
      x = ginv(a);
      return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
      return o;
   endfunction

   // Byte index is row + 4*column; row r rotates left by r columns.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

   always_comb begin
      enc_next = shift_rows(sub_bytes(blk));
      if (cnt != NR_CNT) enc_next = mix_columns(enc_next);
      enc_next = enc_next ^ round_keys[KW-1-128*int'(cnt) -: 128];
   end

`ifdef AES_ROUND_ENGINE_DEC_EN
   logic         mode_r;
   logic [127:0] dec_next;

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return ginv(rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05);
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
      return o;
   endfunction

   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(r+4*((c+r)%4)) -: 8] = s[127-8*(r+4*c) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
         o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
         o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
         o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
      return o;
   endfunction

   // Straight inverse cipher: round r consumes key Nr-r, ending on rk[0].
   always_comb begin
      dec_next = inv_sub_bytes(inv_shift_rows(blk)) ^ round_keys[KW-1-128*(Nr-int'(cnt)) -: 128];
      if (cnt != NR_CNT) dec_next = inv_mix_columns(dec_next);
   end

   always_ff @(posedge clk) begin
      if (reset)       mode_r <= 1'b0;
      else if (accept) mode_r <= mode;
   end

   assign load_val  = in ^ (mode ? round_keys[127:0] : round_keys[KW-1 -: 128]);
   assign round_val = mode_r ? dec_next : enc_next;
   assign out_mode  = mode_r;
`else
   logic unused_mode;
   assign unused_mode = mode;
   assign load_val    = in ^ round_keys[KW-1 -: 128];
   assign round_val   = enc_next;
   assign out_mode    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) fsm <= IDLE;
      else       fsm <= fsm_next;
   end

   always_comb begin
      fsm_next  = fsm;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      unique case (fsm)
         IDLE: begin
            busy     = 1'b0;
            in_ready = keys_valid & ~reset;
            if (in_valid & in_ready) fsm_next = ROUND;
         end
         ROUND: if (cnt == NR_CNT) fsm_next = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) fsm_next = IDLE;
         end
         default: fsm_next = IDLE;
      endcase
   end

   assign accept = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         blk <= '0;
         cnt <= '0;
      end else if (accept) begin
         blk <= load_val;
         cnt <= 4'd1;
      end else if (fsm == ROUND) begin
         blk <= round_val;
         cnt <= cnt + 4'd1;
      end
   end

   assign out = blk;
endmodule

// File: tb/tb_aes_round_engine.sv
// Bench for aes_round_engine: FIPS-197 vectors for Nk=4/6/8 plus handshake, reset and gating sequences.
module tb_aes_round_engine;
   localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, keys_valid, mode, out_ready;
   logic [127:0]  din;
   logic [2:0]    iv, rdy, ov, om, bsy;
   logic [127:0]  o4, o6, o8;
   logic [1407:0] rk4;
   logic [1663:0] rk6;
   logic [1919:0] rk8;

   aes_round_engine #(.Nk(4)) dut4 (.clk(clk), .reset(reset), .keys_valid(keys_valid), .round_keys(rk4),
      .in_valid(iv[0]), .in_ready(rdy[0]), .mode(mode), .in(din), .out_valid(ov[0]), .out_ready(out_ready),
      .out(o4), .out_mode(om[0]), .busy(bsy[0]));
   aes_round_engine #(.Nk(6)) dut6 (.clk(clk), .reset(reset), .keys_valid(keys_valid), .round_keys(rk6),
      .in_valid(iv[1]), .in_ready(rdy[1]), .mode(mode), .in(din), .out_valid(ov[1]), .out_ready(out_ready),
      .out(o6), .out_mode(om[1]), .busy(bsy[1]));
   aes_round_engine #(.Nk(8)) dut8 (.clk(clk), .reset(reset), .keys_valid(keys_valid), .round_keys(rk8),
      .in_valid(iv[2]), .in_ready(rdy[2]), .mode(mode), .in(din), .out_valid(ov[2]), .out_ready(out_ready),
      .out(o8), .out_mode(om[2]), .busy(bsy[2]));

   int           sel = 0;
   logic         c_ov, c_rdy, c_om, c_bsy;
   logic [127:0] c_out;
   always_comb begin
      c_ov  = ov[sel];
      c_rdy = rdy[sel];
      c_om  = om[sel];
      c_bsy = bsy[sel];
      case (sel)
         1:       c_out = o6;
         2:       c_out = o8;
         default: c_out = o4;
      endcase
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Key schedule reference: S-box generated by walking GF(2^8) with generator 3.
   logic [7:0] sb [256];

   function automatic logic [7:0] rl(input logic [7:0] b, input int n);
      return 8'((b << n) | (b >> (8 - n)));
   endfunction

   task automatic build_sbox();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ 8'(p << 1) ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ 8'(q << 1);
         q = q ^ 8'(q << 2);
         q = q ^ 8'(q << 4);
         if (q[7]) q = q ^ 8'h09;
         x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
         sb[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sb[0] = 8'h63;
   endtask

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
   endfunction

   function automatic logic [1919:0] expand(input int nk, input logic [255:0] key);
      logic [31:0]   w [60];
      logic [31:0]   t;
      logic [7:0]    rc;
      logic [1919:0] r;
      rc = 8'h01;
      r  = '0;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(nk+7); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end else if (nk > 6 && i % nk == 4) begin
            t = sub_word(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int i = 0; i < 4*(nk+7); i++) r[1919-32*i -: 32] = w[i];
      return r;
   endfunction

   typedef struct packed { logic [127:0] d; logic m; } exp_t;
   exp_t sbq [$];

   typedef struct { int s; logic [127:0] din; logic md; logic [127:0] dexp; logic mexp; int lat; } vec_t;
   vec_t vt [6];

   task automatic accept_block(input int s, input logic [127:0] d, input logic m,
                               input logic [127:0] ed, input logic em);
      exp_t e;
      sel   = s;
      din   = d;
      mode  = m;
      iv[s] = 1'b1;
      #1 chk("in_ready_idle", 128'(c_rdy), 128'd1);
      @(negedge clk);
      iv[s] = 1'b0;
      mode  = ~m;
      e.d = ed;
      e.m = em;
      sbq.push_back(e);
      chk("busy_after_accept", 128'(c_bsy), 128'd1);
   endtask

   task automatic wait_result(input int lat, input string name);
      int   n = 0;
      exp_t e;
      while (!c_ov && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_latency"}, 128'(n), 128'(lat));
      if (sbq.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s_queue: got empty, want entry", name);
      end else begin
         e = sbq.pop_front();
         chk({name, "_out"}, c_out, e.d);
         chk({name, "_out_mode"}, 128'(c_om), 128'(e.m));
      end
   endtask

   task automatic handshake(input string name);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({name, "_ov_cleared"}, 128'(c_ov), 128'd0);
      chk({name, "_in_ready_back"}, 128'(c_rdy), 128'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1);
   end

   initial begin
      logic [1919:0] e;
      int hits, last;
      build_sbox();
      e   = expand(4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
      rk4 = e[1919 -: 1408];
      e   = expand(6, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0});
      rk6 = e[1919 -: 1664];
      rk8 = expand(8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);

      vt[0] = '{0, PT, 1'b0, CT128, 1'b0, 10};
      vt[2] = '{1, PT, 1'b0, CT192, 1'b0, 12};
      vt[3] = '{2, PT, 1'b0, CT256, 1'b0, 14};
`ifdef AES_ROUND_ENGINE_DEC_EN
      vt[1] = '{0, CT128, 1'b1, PT, 1'b1, 10};
      vt[4] = '{1, CT192, 1'b1, PT, 1'b1, 12};
      vt[5] = '{2, CT256, 1'b1, PT, 1'b1, 14};
`else
      vt[1] = '{0, PT, 1'b1, CT128, 1'b0, 10};
      vt[4] = '{1, PT, 1'b1, CT192, 1'b0, 12};
      vt[5] = '{2, PT, 1'b1, CT256, 1'b0, 14};
`endif

      reset = 1'b1; keys_valid = 1'b1; mode = 1'b0; out_ready = 1'b0; din = '0; iv = '0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 128'(c_rdy), 128'd0);
      chk("rst_out_valid", 128'(c_ov), 128'd0);
      chk("rst_out", c_out, 128'd0);
      chk("rst_out_mode", 128'(c_om), 128'd0);
      chk("rst_busy", 128'(c_bsy), 128'd0);
      reset = 1'b0;
      #1 chk("rst_release_ready", 128'(c_rdy), 128'd1);

      for (int i = 0; i < 6; i++) begin
         accept_block(vt[i].s, vt[i].din, vt[i].md, vt[i].dexp, vt[i].mexp);
         wait_result(vt[i].lat, $sformatf("vec%0d", i));
         handshake($sformatf("vec%0d", i));
      end

      // Backpressure with a competing input, then output and input offered in the same cycle.
      accept_block(0, PT, 1'b0, CT128, 1'b0);
      wait_result(10, "bp");
      din = PT; mode = 1'b0; iv[0] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_out_hold", c_out, CT128);
         chk("bp_valid_hold", 128'(c_ov), 128'd1);
         chk("bp_in_ready_low", 128'(c_rdy), 128'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("same_cycle_no_accept", 128'(c_bsy), 128'd0);
      chk("same_cycle_ready", 128'(c_rdy), 128'd1);
      accept_block(0, PT, 1'b0, CT128, 1'b0);
      wait_result(10, "bp_next");
      handshake("bp_next");

      // Streaming with out_ready held high from the start.
      sel = 0; din = PT; mode = 1'b0; iv[0] = 1'b1; out_ready = 1'b1;
      hits = 0; last = 0;
      for (int k = 1; k <= 36; k++) begin
         @(negedge clk);
         if (c_ov) begin
            chk("b2b_out", c_out, CT128);
            if (hits > 0) chk("b2b_period", 128'(k - last), 128'd12);
            else          chk("b2b_first", 128'(k), 128'd11);
            hits++;
            last = k;
         end
      end
      iv[0] = 1'b0; out_ready = 1'b0;
      chk("b2b_count", 128'(hits), 128'd3);
      chk("b2b_idle", 128'(c_bsy), 128'd0);

      // Reset four cycles into a block.
      din = PT; mode = 1'b0; iv[0] = 1'b1;
      @(negedge clk);
      iv[0] = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_mid_busy", 128'(c_bsy), 128'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_mid_ov", 128'(c_ov), 128'd0);
      chk("rst_mid_busy_low", 128'(c_bsy), 128'd0);
      chk("rst_mid_out", c_out, 128'd0);
      accept_block(0, PT, 1'b0, CT128, 1'b0);
      wait_result(10, "post_rst");

      // Reset while the result waits in DONE.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_done_ov", 128'(c_ov), 128'd0);
      chk("rst_done_out", c_out, 128'd0);

      // keys_valid gating; dropping it mid-block must not abort the block.
      keys_valid = 1'b0; din = PT; mode = 1'b0; iv[0] = 1'b1;
      #1 chk("gate_in_ready", 128'(c_rdy), 128'd0);
      @(negedge clk);
      chk("gate_no_accept", 128'(c_bsy), 128'd0);
      keys_valid = 1'b1;
      #1 chk("gate_in_ready_up", 128'(c_rdy), 128'd1);
      @(negedge clk);
      iv[0] = 1'b0; keys_valid = 1'b0;
      sbq.push_back({CT128, 1'b0});
      chk("gate_accept", 128'(c_bsy), 128'd1);
      wait_result(10, "gate");
      keys_valid = 1'b1;
      handshake("gate");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
